// File: rtl/uart_pkg.sv
// Shared UART byte types and the arbiter FSM encoding.
package uart_pkg;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK  = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   typedef logic [DATA_W-1:0] tx_byte_t;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams plus the uart_tx byte port, grouped for the arbiter.
interface uart_tx_arbiter_if import uart_pkg::*; #(
   parameter int NREQ = 4
) ();
   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0]        req_valid;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        req_last;
   logic [NREQ-1:0]        req_ready;
   logic                   tx_valid;
   tx_byte_t               tx_data;
   logic                   tx_ready;
   logic [IW-1:0]          grant_id;
   logic                   busy;

   modport master (
      input  req_valid, req_data, req_last, tx_ready,
      output req_ready, tx_valid, tx_data, grant_id, busy
   );

   modport slave (
      output req_valid, req_data, req_last, tx_ready,
      input  req_ready, tx_valid, tx_data, grant_id, busy
   );
endinterface

// File: rtl/rr_picker.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping modulo NREQ.
module rr_picker #(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   idx,
   output logic            found
);
   int            pos;
   logic [IW-1:0] pos_idx;

   // Scan from the far end so the candidate nearest to ptr is written last and wins.
   always_comb begin
      idx     = '0;
      found   = 1'b0;
      pos     = 0;
      pos_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= NREQ) pos = pos - NREQ;
         pos_idx = IW'(pos);
         if (req[pos_idx]) begin
            idx   = pos_idx;
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding one uart_tx through a one-entry buffer;
// request to tx_valid is two cycles, and a stalled tx_ready stops accepts once the buffer is full.
module uart_tx_arbiter import uart_pkg::*; #(
   parameter int NREQ = 4,
   parameter int MAXB = 16
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.master bus
);
   localparam int IW = $clog2(NREQ);

   arb_state_t    state, state_nxt;
   logic [IW-1:0] ptr, ptr_nxt;
   logic [IW-1:0] gnt, gnt_nxt;
   logic [7:0]    bcnt, bcnt_nxt;
   logic [IW-1:0] pick_idx;
   logic          pick_found;
   logic          accept, last_byte, hs;
   tx_byte_t      sel_data;

   rr_picker #(.NREQ(NREQ)) u_pick (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign hs        = bus.tx_valid && bus.tx_ready;
   // The buffer can take a byte when empty or when it is being emptied this same cycle.
   assign accept    = (state == LOCK) && bus.req_valid[gnt] && (!bus.tx_valid || bus.tx_ready);
   assign last_byte = bus.req_last[gnt] || (({1'b0, bcnt} + 9'd1) == 9'(MAXB));
   assign bus.grant_id = gnt;
   assign bus.busy     = (state != IDLE);

   always_comb begin
      bus.req_ready = '0;
      sel_data      = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt == IW'(i)) begin
            bus.req_ready[i] = accept;
            sel_data         = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      ptr_nxt   = ptr;
      bcnt_nxt  = bcnt;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt = LOCK;
               gnt_nxt   = pick_idx;
               bcnt_nxt  = 8'd0;
            end
         end
         LOCK: begin
            if (accept) begin
               bcnt_nxt = bcnt + 8'd1;
               if (last_byte) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // No reloads happen here, so any handshake empties the buffer.
            if (hs) begin
               state_nxt = IDLE;
               ptr_nxt   = (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         gnt   <= '0;
         ptr   <= '0;
         bcnt  <= 8'd0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         ptr   <= ptr_nxt;
         bcnt  <= bcnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.tx_valid <= 1'b0;
         bus.tx_data  <= '0;
      end else if (accept) begin
         bus.tx_valid <= 1'b1;
         bus.tx_data  <= sel_data;
      end else if (hs) begin
         bus.tx_valid <= 1'b0;
      end
   end
endmodule
